mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 mux datapath between two requesters, A and B.
- Drives the mux select line and returns a per-requester grant.
- Sits directly in front of the 2:1 mux: SEL from this block feeds the mux SEL input.
- A grant is held while the owner keeps requesting. Ties alternate fairly.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced handover (used only with the optional feature); legal range 1..255.
- HOLD_W, 8: width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- CLK  input  1  single clock, all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_A  input  1  requester A wants the mux (level).
- REQ_B  input  1  requester B wants the mux (level).
- GNT_A  output  1  A owns the mux (registered).
- GNT_B  output  1  B owns the mux (registered).
- SEL  output  1  mux select: 0 routes A, 1 routes B (registered).
- BUSY  output  1  GNT_A | GNT_B.
- PREEMPT  output  1  one-cycle pulse when a grant is forcibly handed over.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values: GNT_A=0, GNT_B=0, SEL=0, PREEMPT=0, state=IDLE, hold counter=0, LAST=1 (B treated as last owner, so A wins the first tie).
- States:
  - IDLE: no grant.
  - OWN_A: GNT_A=1, SEL=0.
  - OWN_B: GNT_B=1, SEL=1.
- Latency: a request sampled at edge n gives a grant visible after edge n. The grant deasserts in the cycle after the owner's REQ is sampled low.
- IDLE transitions:
  - REQ_A only -> OWN_A.
  - REQ_B only -> OWN_B.
  - Both requesting -> the requester that is not LAST.
  - Neither requesting -> stay in IDLE.
- OWN_A transitions (OWN_B is symmetric):
  - REQ_A=1 -> stay in OWN_A.
  - REQ_A=0 and REQ_B=1 -> OWN_B directly, with no idle gap.
  - REQ_A=0 and REQ_B=0 -> IDLE.
- LAST updates on every entry into OWN_A or OWN_B.
- SEL in IDLE keeps its last value, so the mux output does not glitch.
- GNT_A and GNT_B are never both 1 (mutual exclusion invariant).
- Hold counter:
  - Clears on any state entry.
  - Increments each cycle in an OWN state and saturates at MAX_HOLD.
- Reset asserted mid-grant: the next edge forces reset values regardless of REQ.
- A requester that drops and immediately re-raises REQ while the other is waiting loses the tie (round-robin).

Optional Feature:
- Macro: MUX2_RR_ARB_TIMEOUT_EN.
- When defined:
  - In OWN_A, if hold counter == MAX_HOLD-1 and REQ_B=1, the next state is OWN_B even though REQ_A=1.
  - PREEMPT pulses high for exactly the first cycle of the new grant.
  - OWN_B is symmetric.
  - With MAX_HOLD=1, ownership alternates every cycle while both requesters are active.
- When undefined:
  - No preemption; an owner keeps the grant indefinitely.
  - PREEMPT is tied to 0.
  - The hold counter is not instantiated.

Decomposition:
- Shared package/header mux2_arb_defs holds:
  - State encodings: ST_IDLE=2'b00, ST_OWN_A=2'b01, ST_OWN_B=2'b10.
  - Select constants: SEL_A=1'b0, SEL_B=1'b1.
  - The MAX_HOLD default.
- One sub-module, mux2_arb_hold_cnt: saturating counter with clear, enable and terminal-count output. It is instantiated only under the macro.

Test Plan:
- Reset: hold RST=1 for 3 cycles with REQ_A=REQ_B=1 -> GNT_A=GNT_B=0, SEL=0, BUSY=0 throughout. Release RST -> GNT_A=1 one cycle later.
- Single requester: REQ_B=1 for 5 cycles, then 0 -> GNT_B=1 and SEL=1 for 5 cycles, then IDLE with SEL still 1.
- Simultaneous tie:
  - After reset, REQ_A=REQ_B=1 -> GNT_A first.
  - Drop REQ_A for 1 cycle -> direct handover to GNT_B with no idle cycle.
  - Drop both, then raise both -> GNT_A (LAST=B).
- Reset mid-grant: assert RST during OWN_B -> next edge GNT_B=0, SEL=0, LAST=1. With both requests held, A is granted after release.
- Timeout (macro defined, MAX_HOLD=4):
  - Both requesting continuously -> grants alternate A,A,A,A,B,B,B,B,...
  - PREEMPT pulses on each handover.
  - Without the macro: A holds forever and PREEMPT stays 0.
- Continuous checker: a property or monitor flags GNT_A&GNT_B, and flags SEL not matching the owner while BUSY=1.

Source files
------------

// File: rtl/mux2_arb_defs_pkg.sv
// mux2_arb_defs: shared definitions for the 2:1 mux round-robin arbiter.
//   state_t      : FSM encoding (IDLE / OWN_A / OWN_B)
//   SEL_A, SEL_B : mux select values routing requester A or B
//   MAX_HOLD_DEF : default hold limit used when MUX2_RR_ARB_TIMEOUT_EN is defined
//   HOLD_W_DEF   : default hold counter width
package mux2_arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_OWN_A = 2'b01,
    ST_OWN_B = 2'b10
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int MAX_HOLD_DEF = 8;
  localparam int HOLD_W_DEF   = 8;

endpackage

// File: rtl/mux2_arb_hold_cnt.sv
// mux2_arb_hold_cnt: saturating grant-hold counter with terminal count.
// Only compiled when MUX2_RR_ARB_TIMEOUT_EN is defined (it is only used by
// the arbiter's forced-handover logic).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to 0 (wins over en)
//   en       : count one cycle of ownership, saturating at MAX_HOLD
//   tc       : high while count == MAX_HOLD-1, i.e. the owner's last
//              allowed cycle when someone else is waiting
`ifdef MUX2_RR_ARB_TIMEOUT_EN
module mux2_arb_hold_cnt
  import mux2_arb_defs::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [HOLD_W-1:0] MAX_V = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] TC_V  = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                     cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != MAX_V) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TC_V);

endmodule
`endif

// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: round-robin owner of a shared 2:1 mux.
// SEL feeds the mux select directly; an owner keeps the mux while it keeps
// requesting, ties go to whoever did not own it last.
// Optional macro MUX2_RR_ARB_TIMEOUT_EN: an owner that has held the mux for
// MAX_HOLD cycles is forced to hand over when the other side is waiting,
// and PREEMPT pulses for the first cycle of the new grant. Without it,
// PREEMPT is tied low and no hold counter exists.
// Ports:
//   CLK, RST     : clock, synchronous active-high reset
//   REQ_A, REQ_B : level requests
//   GNT_A, GNT_B : registered grants (never both high)
//   SEL          : registered mux select, 0 = A, 1 = B; held while idle
//   BUSY         : GNT_A | GNT_B
//   PREEMPT      : one-cycle pulse on a forced handover
module mux2_rr_arbiter
  import mux2_arb_defs::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ_A,
  input  logic REQ_B,
  output logic GNT_A,
  output logic GNT_B,
  output logic SEL,
  output logic BUSY,
  output logic PREEMPT
);

  // Parameter sanity check at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_param
    $error("mux2_rr_arbiter: illegal MAX_HOLD/HOLD_W");
  end

  state_t state, nxt;
  logic   last;      // 1: B owned the mux last, so A wins the next tie
  logic   hold_tc;   // current owner is on its last allowed cycle
  logic   entry;     // nxt is a different state than the current one

  assign entry = (nxt != state);

`ifdef MUX2_RR_ARB_TIMEOUT_EN
  logic preempt_nxt;

  mux2_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_hold_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (entry),
    .en  (state != ST_IDLE),
    .tc  (hold_tc)
  );

  // A handover is forced only if the outgoing owner still wanted the mux.
  assign preempt_nxt = (state == ST_OWN_A && nxt == ST_OWN_B && REQ_A) ||
                       (state == ST_OWN_B && nxt == ST_OWN_A && REQ_B);
`else
  assign hold_tc = 1'b0;
  assign PREEMPT = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (REQ_A && REQ_B) nxt = last ? ST_OWN_A : ST_OWN_B;
        else if (REQ_A)     nxt = ST_OWN_A;
        else if (REQ_B)     nxt = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (REQ_A) nxt = (hold_tc && REQ_B) ? ST_OWN_B : ST_OWN_A;
        else       nxt = REQ_B ? ST_OWN_B : ST_IDLE;
      end
      ST_OWN_B: begin
        if (REQ_B) nxt = (hold_tc && REQ_A) ? ST_OWN_A : ST_OWN_B;
        else       nxt = REQ_A ? ST_OWN_A : ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // All outputs are registered from the next state so they line up with
  // the state register and cannot glitch the mux select.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      last  <= 1'b1;
      GNT_A <= 1'b0;
      GNT_B <= 1'b0;
      SEL   <= SEL_A;
`ifdef MUX2_RR_ARB_TIMEOUT_EN
      PREEMPT <= 1'b0;
`endif
    end else begin
      state <= nxt;
      GNT_A <= (nxt == ST_OWN_A);
      GNT_B <= (nxt == ST_OWN_B);
      // In IDLE, SEL keeps the previous owner's route.
      if (nxt == ST_OWN_A)      SEL <= SEL_A;
      else if (nxt == ST_OWN_B) SEL <= SEL_B;
      if (entry && nxt == ST_OWN_A) last <= 1'b0;
      if (entry && nxt == ST_OWN_B) last <= 1'b1;
`ifdef MUX2_RR_ARB_TIMEOUT_EN
      PREEMPT <= preempt_nxt;
`endif
    end
  end

  assign BUSY = GNT_A | GNT_B;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter (MAX_HOLD=4). Each step drives inputs
// on the falling edge and queues the outputs expected after the next rising
// edge; a monitor pops and compares after every rising edge, and also
// checks grant exclusivity and SEL/owner agreement while busy.
module tb_mux2_rr_arbiter;

  logic CLK = 1'b0;
  logic RST, REQ_A, REQ_B;
  logic GNT_A, GNT_B, SEL, BUSY, PREEMPT;

  always #5 CLK = ~CLK;

  mux2_rr_arbiter #(
    .MAX_HOLD (4),
    .HOLD_W   (8)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ_A   (REQ_A),
    .REQ_B   (REQ_B),
    .GNT_A   (GNT_A),
    .GNT_B   (GNT_B),
    .SEL     (SEL),
    .BUSY    (BUSY),
    .PREEMPT (PREEMPT)
  );

  typedef struct {
    logic [4:0] exp;   // {gnt_a, gnt_b, sel, preempt, busy}
    int         id;
  } sb_t;

  sb_t q[$];
  int  total = 0;
  int  bad   = 0;
  int  vec_id = 0;

  task automatic step(input logic r, input logic a, input logic b,
                      input logic ga, input logic gb, input logic sel,
                      input logic pre);
    sb_t e;
    @(negedge CLK);
    RST   = r;
    REQ_A = a;
    REQ_B = b;
    e.exp = {ga, gb, sel, pre, ga | gb};
    e.id  = vec_id;
    q.push_back(e);
    vec_id++;
  endtask

  // Monitor / scoreboard
  always @(posedge CLK) begin
    sb_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if ({GNT_A, GNT_B, SEL, PREEMPT, BUSY} !== e.exp) begin
        bad++;
        $display("FAIL vec%0d outs {ga,gb,sel,pre,busy} got=%b want=%b",
                 e.id, {GNT_A, GNT_B, SEL, PREEMPT, BUSY}, e.exp);
      end
      total++;
      if (GNT_A && GNT_B) begin
        bad++;
        $display("FAIL vec%0d mutex got ga=%b gb=%b want not both 1", e.id, GNT_A, GNT_B);
      end
      if (BUSY) begin
        total++;
        if (SEL !== GNT_B) begin
          bad++;
          $display("FAIL vec%0d sel_owner got sel=%b want %b", e.id, SEL, GNT_B);
        end
      end
    end
  end

  initial begin
    int guard;
    RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1;

    // Reset held with both requesting: nothing granted.
    repeat (3) step(1, 1, 1, 0, 0, 0, 0);
    // Release: A wins the first tie.
    step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    // A drops, B waiting: direct handover, no idle gap.
    repeat (4) step(0, 0, 1, 0, 1, 1, 0);
    // Idle: SEL stays on B.
    repeat (2) step(0, 0, 0, 0, 0, 1, 0);
    // Single requester B for 5 cycles, then idle with SEL still 1.
    repeat (5) step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    // Tie from idle with B last: A.
    step(0, 1, 1, 1, 0, 0, 0);
    // Drop A one cycle: B, and B keeps it when A comes back.
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    // Drop both, raise both: A (B was last).
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    // A drops and re-raises while B waits: A loses.
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    // Reset mid-grant, then A wins after release.
    step(1, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
`ifdef MUX2_RR_ARB_TIMEOUT_EN
    // Both held: 4 cycles each, PREEMPT on every handover.
    repeat (3) step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 1, 1);
    repeat (3) step(0, 1, 1, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0, 0, 1);
    repeat (3) step(0, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);
`else
    // Both held: A keeps the mux, never preempted.
    repeat (12) step(0, 1, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
`endif

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge CLK);
      guard++;
    end
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
